// File: rtl/load_store_unit.sv
// load_store_unit
// Byte-addressed RV32I load/store front end for a word-addressed data memory
// with no byte enables. Sub-word stores are done as read-modify-write within
// the LO/HI memory cycles; accesses that straddle a word boundary take two
// memory cycles (LO = first word, HI = next word, index wrapping to 0).
// Loads are sign/zero-extended according to funct3.
//
// Optional build macro: LSU_MISALIGN_TRAP_EN
//   When defined, misaligned halfword/word accesses are not split. They
//   complete IDLE->DONE with resp_err=1 and no memory access.
//   When undefined (default), misaligned accesses are split across two words.

module load_store_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int INDEX_WIDTH = 30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_store,
    input  logic [2:0]            req_funct3,
    input  logic [DATA_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_wd,
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Helper functions
    // ------------------------------------------------------------------

    // funct3 legality: stores only allow SB/SH/SW, loads reject 011/110/111.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        if (is_store) begin
            case (f3)
                3'b000, 3'b001, 3'b010: ok = 1'b1;
                default:                ok = 1'b0;
            endcase
        end else begin
            case (f3)
                3'b011, 3'b110, 3'b111: ok = 1'b0;
                default:                ok = 1'b1;
            endcase
        end
        return ok;
    endfunction

    // Byte lanes touched across the two-word window {hi, lo}; bits [7:4]
    // being non-zero means the access spills into the next word.
    function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] f3);
        logic [7:0] m;
        case (f3[1:0])
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    // Replace the enabled byte lanes of a memory word with the inserted data.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] ins_word,
                                               input logic [3:0]  en);
        logic [31:0] mask;
        for (int i = 0; i < 4; i++) begin
            mask[i*8 +: 8] = {8{en[i]}};
        end
        return (old_word & ~mask) | (ins_word & mask);
    endfunction

    // Pick the addressed bytes out of {hi, lo} and extend per funct3.
    function automatic logic [31:0] extract_load(input logic [31:0] lo_word,
                                                 input logic [31:0] hi_word,
                                                 input logic [1:0]  off,
                                                 input logic [2:0]  f3);
        logic [63:0] both;
        logic [31:0] raw;
        logic [31:0] res;
        both = {hi_word, lo_word} >> {off, 3'b000};
        raw  = both[31:0];
        case (f3)
            3'b000:  res = {{24{raw[7]}}, raw[7:0]};
            3'b001:  res = {{16{raw[15]}}, raw[15:0]};
            3'b010:  res = raw;
            3'b100:  res = {24'd0, raw[7:0]};
            3'b101:  res = {16'd0, raw[15:0]};
            default: res = 32'd0;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                  state_r;
    state_t                  next_state_s;
    logic                    store_r;
    logic [2:0]              funct3_r;
    logic [DATA_WIDTH-1:0]   addr_r;
    logic [DATA_WIDTH-1:0]   wdata_r;
    logic [DATA_WIDTH-1:0]   lo_word_r;
    logic [DATA_WIDTH-1:0]   hi_word_r;
    logic                    err_r;

    // Request decode (only meaningful in IDLE)
    logic                    misalign_s;
    logic                    bad_req_s;

    // Latched-request derived signals
    logic [7:0]              lanes_s;
    logic                    cross_s;
    logic [63:0]             sdata_s;
    logic [INDEX_WIDTH-1:0]  index_s;
    logic [INDEX_WIDTH-1:0]  index_next_s;
    logic [DATA_WIDTH-1:0]   load_data_s;

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_s = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    assign misalign_s = 1'b0;
`endif

    assign bad_req_s    = !funct3_legal(req_store, req_funct3) || misalign_s;
    assign lanes_s      = lane_mask(addr_r[1:0], funct3_r);
    assign cross_s      = |lanes_s[7:4];
    assign sdata_s      = {32'd0, wdata_r} << {addr_r[1:0], 3'b000};
    assign index_s      = addr_r[DATA_WIDTH-1:2];
    assign index_next_s = index_s + {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    assign load_data_s  = extract_load(lo_word_r, hi_word_r, addr_r[1:0], funct3_r);

    // State register with asynchronous reset to IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request latch on accept and load-word capture in LO/HI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            store_r   <= 1'b0;
            funct3_r  <= 3'd0;
            addr_r    <= 32'd0;
            wdata_r   <= 32'd0;
            lo_word_r <= 32'd0;
            hi_word_r <= 32'd0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        store_r  <= req_store;
                        funct3_r <= req_funct3;
                        addr_r   <= req_addr;
                        wdata_r  <= req_wdata;
                        err_r    <= bad_req_s;
                    end
                end
                LO: begin
                    if (!store_r) begin
                        lo_word_r <= mem_rd;
                    end
                end
                HI: begin
                    if (!store_r) begin
                        hi_word_r <= mem_rd;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic: error short-cut, optional second word, response hold
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    if (bad_req_s) begin
                        next_state_s = DONE;
                    end else begin
                        next_state_s = LO;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            LO: begin
                if (cross_s) begin
                    next_state_s = HI;
                end else begin
                    next_state_s = DONE;
                end
            end
            HI: begin
                next_state_s = DONE;
            end
            DONE: begin
                if (resp_ready) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DONE;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Output decode: memory port in LO/HI, response in DONE, zeros elsewhere
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_rdata = 32'd0;
        resp_err   = 1'b0;
        mem_addr   = 32'd0;
        mem_we     = 1'b0;
        mem_wd     = 32'd0;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
            end
            LO: begin
                mem_addr = {2'b00, index_s};
                if (store_r) begin
                    mem_we = 1'b1;
                    mem_wd = merge_word(mem_rd, sdata_s[31:0], lanes_s[3:0]);
                end else begin
                    mem_we = 1'b0;
                end
            end
            HI: begin
                mem_addr = {2'b00, index_next_s};
                if (store_r) begin
                    mem_we = 1'b1;
                    mem_wd = merge_word(mem_rd, sdata_s[63:32], lanes_s[7:4]);
                end else begin
                    mem_we = 1'b0;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_r;
                if (err_r || store_r) begin
                    resp_rdata = 32'd0;
                end else begin
                    resp_rdata = load_data_s;
                end
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit with a 16-word memory model
// (word index low 4 bits select the entry, so index 0x3FFFFFFF maps to entry 15).

module tb_load_store_unit;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    logic [31:0] mem [0:15];
    logic        do_preload;

    int checks;
    int errors;

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rd = mem[mem_addr[3:0]];

    // Memory model: preload image on request, otherwise accept unit writes
    always @(posedge clk) begin
        if (do_preload) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0000_0000;
            mem[0]  <= 32'h0000_00CD;
            mem[1]  <= 32'h4433_2211;
            mem[2]  <= 32'h8877_6655;
            mem[3]  <= 32'h0000_80F0;
            mem[15] <= 32'hAB00_0000;
        end else if (mem_we) begin
            mem[mem_addr[3:0]] <= mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload();
        @(negedge clk);
        do_preload = 1'b1;
        @(negedge clk);
        do_preload = 1'b0;
    endtask

    // Issue one request and watch it until resp_valid (bounded).
    // lat = negedges after the accept edge at which resp_valid was first seen
    // (0 = never seen). a1/a2 = mem_addr on the first/second cycle after accept.
    task automatic run_req(input logic st, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int lat, output int wes,
                           output logic [31:0] rd, output logic er,
                           output logic [31:0] a1, output logic [31:0] a2);
        lat = 0; wes = 0; rd = 32'h0; er = 1'b0; a1 = 32'h0; a2 = 32'h0;
        @(negedge clk);
        req_valid = 1'b1; req_store = st; req_funct3 = f3;
        req_addr = a; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) a1 = mem_addr;
            if (k == 2) a2 = mem_addr;
            if (mem_we) wes++;
            if (resp_valid) begin
                lat = k;
                rd  = resp_rdata;
                er  = resp_err;
                break;
            end
        end
    endtask

    int          lat, wes;
    logic [31:0] rd, a1, a2;
    logic        er;

    initial begin
        checks = 0; errors = 0;
        rst = 1'b1; do_preload = 1'b0;
        req_valid = 1'b0; req_store = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b1;

        // Reset state
        @(posedge clk);
        do_preload = 1'b1;
        @(posedge clk);
        #1;
        do_preload = 1'b0;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1. Aligned word load and intra-word byte load
        run_req(1'b0, 3'b010, 32'h4, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lw4_lat", lat, 32'd2);
        chk("lw4_data", rd, 32'h4433_2211);
        chk("lw4_err", {31'd0, er}, 32'd0);
        chk("lw4_addr", a1, 32'd1);
        run_req(1'b0, 3'b000, 32'h7, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lb7_data", rd, 32'h0000_0044);
        chk("lb7_lat", lat, 32'd2);

        // 2. Sign and zero extension
        run_req(1'b0, 3'b000, 32'hC, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lbC_data", rd, 32'hFFFF_FFF0);
        run_req(1'b0, 3'b100, 32'hC, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lbuC_data", rd, 32'h0000_00F0);
        run_req(1'b0, 3'b001, 32'hC, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lhC_data", rd, 32'hFFFF_80F0);
        run_req(1'b0, 3'b101, 32'hC, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lhuC_data", rd, 32'h0000_80F0);

        // 3. Sub-word store via read-modify-write
        run_req(1'b1, 3'b000, 32'h5, 32'h1234_56AB, lat, wes, rd, er, a1, a2);
        chk("sb5_we_pulses", wes, 32'd1);
        chk("sb5_index", a1, 32'd1);
        chk("sb5_word1", mem[1], 32'h4433_AB11);
        chk("sb5_rdata", rd, 32'd0);
        chk("sb5_lat", lat, 32'd2);

        // 4. Word-crossing accesses
        preload();
`ifdef LSU_MISALIGN_TRAP_EN
        run_req(1'b0, 3'b010, 32'h6, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lw6_err", {31'd0, er}, 32'd1);
        chk("lw6_lat", lat, 32'd1);
        chk("lw6_data", rd, 32'd0);
        run_req(1'b1, 3'b010, 32'h7, 32'hDEAD_BEEF, lat, wes, rd, er, a1, a2);
        chk("sw7_err", {31'd0, er}, 32'd1);
        chk("sw7_lat", lat, 32'd1);
        chk("sw7_we_pulses", wes, 32'd0);
        chk("sw7_word1", mem[1], 32'h4433_2211);
        chk("sw7_word2", mem[2], 32'h8877_6655);
`else
        run_req(1'b0, 3'b010, 32'h6, 32'h0, lat, wes, rd, er, a1, a2);
        chk("lw6_data", rd, 32'h6655_4433);
        chk("lw6_lat", lat, 32'd3);
        chk("lw6_hi_index", a2, 32'd2);
        run_req(1'b1, 3'b010, 32'h7, 32'hDEAD_BEEF, lat, wes, rd, er, a1, a2);
        chk("sw7_we_pulses", wes, 32'd2);
        chk("sw7_lat", lat, 32'd3);
        chk("sw7_word1", mem[1], 32'hEF33_2211);
        chk("sw7_word2", mem[2], 32'h88DE_ADBE);
`endif

        // 5. Illegal funct3 and response back-pressure
        run_req(1'b0, 3'b011, 32'h4, 32'h0, lat, wes, rd, er, a1, a2);
        chk("ill_ld_err", {31'd0, er}, 32'd1);
        chk("ill_ld_lat", lat, 32'd1);
        chk("ill_ld_we", wes, 32'd0);
        chk("ill_ld_rdata", rd, 32'd0);
        run_req(1'b1, 3'b100, 32'h8, 32'hFFFF_FFFF, lat, wes, rd, er, a1, a2);
        chk("ill_st_err", {31'd0, er}, 32'd1);
        chk("ill_st_we", wes, 32'd0);

        preload();
        resp_ready = 1'b0;
        run_req(1'b0, 3'b010, 32'h4, 32'h0, lat, wes, rd, er, a1, a2);
        chk("stall_lat", lat, 32'd2);
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("stall_valid", {31'd0, resp_valid}, 32'd1);
            chk("stall_rdata", resp_rdata, 32'h4433_2211);
            chk("stall_err", {31'd0, resp_err}, 32'd0);
            chk("stall_req_ready", {31'd0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_idle", {31'd0, req_ready}, 32'd1);
        chk("stall_release_valid", {31'd0, resp_valid}, 32'd0);

        // 6. Index wrap and reset during an operation
`ifdef LSU_MISALIGN_TRAP_EN
        run_req(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, lat, wes, rd, er, a1, a2);
        chk("wrap_err", {31'd0, er}, 32'd1);
        chk("wrap_lat", lat, 32'd1);

        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h8; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstop_lo_we", {31'd0, mem_we}, 32'd1);
        chk("rstop_lo_addr", mem_addr, 32'd2);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("rstop_valid", {31'd0, resp_valid}, 32'd0);
        chk("rstop_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstop_word2_kept", mem[2], 32'hDEAD_BEEF);
        chk("rstop_ready_after", {31'd0, req_ready}, 32'd1);
`else
        run_req(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, lat, wes, rd, er, a1, a2);
        chk("wrap_lo_index", a1, 32'h3FFF_FFFF);
        chk("wrap_hi_index", a2, 32'h0000_0000);
        chk("wrap_data", rd, 32'hFFFF_CDAB);
        chk("wrap_lat", lat, 32'd3);

        preload();
        @(negedge clk);
        req_valid = 1'b1; req_store = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'h7; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rsthi_lo_we", {31'd0, mem_we}, 32'd1);
        chk("rsthi_lo_wd", mem_wd, 32'hEF33_2211);
        @(posedge clk);
        #1;
        chk("rsthi_hi_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rsthi_we_drop", {31'd0, mem_we}, 32'd0);
        chk("rsthi_mem_addr", mem_addr, 32'd0);
        chk("rsthi_mem_wd", mem_wd, 32'd0);
        chk("rsthi_valid", {31'd0, resp_valid}, 32'd0);
        chk("rsthi_rdata", resp_rdata, 32'd0);
        chk("rsthi_err", {31'd0, resp_err}, 32'd0);
        chk("rsthi_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rsthi_word2", mem[2], 32'h8877_6655);
        chk("rsthi_word1_kept", mem[1], 32'hEF33_2211);
        chk("rsthi_ready_after", {31'd0, req_ready}, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
